// File: rtl/pc_redirect.sv
// pc_redirect: fetch program counter and control-transfer redirect unit.
// It resolves conditional branches, JAL and JALR in the EX stage and steers
// the fetch PC to the computed target. A one-cycle SQUASH state then flushes
// the wrong-path instruction in ID and EX. It also keeps 32-bit counters of
// resolved and taken conditional branches.
module pc_redirect #(
    parameter int                 DWIDTH   = 32,
    parameter logic [DWIDTH-1:0]  BASEADDR = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              ex_valid_i,
    input  logic [6:0]        ex_opcode_i,
    input  logic [2:0]        ex_funct3_i,
    input  logic [DWIDTH-1:0] ex_pc_i,
    input  logic [DWIDTH-1:0] ex_imm_i,
    input  logic [DWIDTH-1:0] ex_rs1_i,
    input  logic              breq_i,
    input  logic              brlt_i,
    output logic [DWIDTH-1:0] pc_o,
    output logic              flush_o,
    output logic              kill_ex_o,
    output logic              misalign_o,
    output logic [31:0]       branch_count_o,
    output logic [31:0]       taken_count_o
);

    // RV32 control-transfer opcodes
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;

    // Branch funct3 encodings; 010 and 011 are reserved and never taken
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Sequential fetch step, sized to the PC width
    localparam logic [DWIDTH-1:0] PC_STEP = {{(DWIDTH-3){1'b0}}, 3'b100};

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    // Target for branches and JAL: PC-relative, wraps modulo 2^DWIDTH
    function automatic logic [DWIDTH-1:0] pc_rel_target(
        input logic [DWIDTH-1:0] base,
        input logic [DWIDTH-1:0] imm
    );
        pc_rel_target = base + imm;
    endfunction

    // Target for JALR: register-relative with bit 0 forced low
    function automatic logic [DWIDTH-1:0] reg_rel_target(
        input logic [DWIDTH-1:0] base,
        input logic [DWIDTH-1:0] imm
    );
        logic [DWIDTH-1:0] sum;
        sum    = base + imm;
        sum[0] = 1'b0;
        reg_rel_target = sum;
    endfunction

    // A target is misaligned when it is not on a 4-byte boundary
    function automatic logic is_misaligned(input logic [DWIDTH-1:0] addr);
        is_misaligned = (addr[1:0] != 2'b00);
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [DWIDTH-1:0]   pc_r;
    logic [DWIDTH-1:0]   pc_next_s;
    logic                flush_r;
    logic                kill_ex_r;
    logic                misalign_r;
    logic [31:0]         branch_count_r;
    logic [31:0]         taken_count_r;

    logic                is_branch_s;
    logic                is_jal_s;
    logic                is_jalr_s;
    logic                branch_cond_s;
    logic                resolve_en_s;
    logic                redirect_s;
    logic                count_branch_s;
    logic                count_taken_s;
    logic [DWIDTH-1:0]   target_s;

    // Decode the EX opcode into control-transfer classes
    always_comb begin
        is_branch_s = 1'b0;
        is_jal_s    = 1'b0;
        is_jalr_s   = 1'b0;
        case (ex_opcode_i)
            OP_BRANCH: is_branch_s = 1'b1;
            OP_JAL:    is_jal_s    = 1'b1;
            OP_JALR:   is_jalr_s   = 1'b1;
            default: begin
                is_branch_s = 1'b0;
                is_jal_s    = 1'b0;
                is_jalr_s   = 1'b0;
            end
        endcase
    end

    // Evaluate the branch condition selected by funct3
    always_comb begin
        branch_cond_s = 1'b0;
        case (ex_funct3_i)
            F3_BEQ:  branch_cond_s = breq_i;
            F3_BNE:  branch_cond_s = ~breq_i;
            F3_BLT:  branch_cond_s = brlt_i;
            F3_BGE:  branch_cond_s = ~brlt_i;
            F3_BLTU: branch_cond_s = brlt_i;
            F3_BGEU: branch_cond_s = ~brlt_i;
            default: branch_cond_s = 1'b0;
        endcase
    end

    // Resolve the EX instruction: only real instructions in RUN may redirect or count
    always_comb begin
        resolve_en_s   = (state_r == ST_RUN) && ex_valid_i;
        redirect_s     = 1'b0;
        count_branch_s = 1'b0;
        count_taken_s  = 1'b0;
        if (resolve_en_s) begin
            redirect_s     = is_jal_s || is_jalr_s || (is_branch_s && branch_cond_s);
            count_branch_s = is_branch_s;
            count_taken_s  = is_branch_s && branch_cond_s;
        end else begin
            redirect_s     = 1'b0;
            count_branch_s = 1'b0;
            count_taken_s  = 1'b0;
        end
    end

    // Select the redirect target for the EX instruction class
    always_comb begin
        target_s = pc_rel_target(ex_pc_i, ex_imm_i);
        if (is_jalr_s) begin
            target_s = reg_rel_target(ex_rs1_i, ex_imm_i);
        end else begin
            target_s = pc_rel_target(ex_pc_i, ex_imm_i);
        end
    end

    // Next-state logic: a redirect opens a single SQUASH cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (redirect_s) begin
                    state_next_s = ST_SQUASH;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_SQUASH: state_next_s = ST_RUN;
            default:   state_next_s = ST_RUN;
        endcase
    end

    // Next fetch PC: redirect beats stall; SQUASH always advances sequentially
    always_comb begin
        pc_next_s = pc_r;
        case (state_r)
            ST_RUN: begin
                if (redirect_s) begin
                    pc_next_s = target_s;
                end else if (stall_i) begin
                    pc_next_s = pc_r;
                end else begin
                    pc_next_s = pc_r + PC_STEP;
                end
            end
            ST_SQUASH: pc_next_s = pc_r + PC_STEP;
            default:   pc_next_s = BASEADDR;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fetch PC register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= BASEADDR;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Registered squash controls and misalignment pulse for the cycle after a redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_r    <= 1'b0;
            kill_ex_r  <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            flush_r    <= (state_next_s == ST_SQUASH);
            kill_ex_r  <= (state_next_s == ST_SQUASH);
            misalign_r <= redirect_s && is_misaligned(target_s);
        end
    end

    // Conditional-branch statistics; both counters wrap silently
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count_r <= 32'h0000_0000;
            taken_count_r  <= 32'h0000_0000;
        end else begin
            if (count_branch_s) begin
                branch_count_r <= branch_count_r + 32'h0000_0001;
            end
            if (count_taken_s) begin
                taken_count_r <= taken_count_r + 32'h0000_0001;
            end
        end
    end

    assign pc_o           = pc_r;
    assign flush_o        = flush_r;
    assign kill_ex_o      = kill_ex_r;
    assign misalign_o     = misalign_r;
    assign branch_count_o = branch_count_r;
    assign taken_count_o  = taken_count_r;

endmodule
